fp_mul_hs: RTL and testbench
============================

FP_MUL_HS -- requirements
Module: fp_mul_hs

Interface
REQ-001 SHALL have parameter EXP_W, 8, exponent field width (min 4).
REQ-002 SHALL have parameter MAN_W, 23, stored fraction width (min 4); word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operands present.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  W  IEEE-754-style operand A.
REQ-008 SHALL have port b  input  W  operand B.
REQ-009 SHALL have port rm  input  2  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port z  output  W  product.
REQ-013 SHALL have port flags  output  4  {invalid, overflow, underflow, inexact}.

Function
REQ-014 SHALL accept a, b and rm into internal registers on a clk edge where in_valid && in_ready; later input changes SHALL NOT affect that result.
REQ-015 SHALL use FSM IDLE -> UNPACK -> MUL -> NORM -> ROUND -> HOLD -> IDLE, advancing one state per cycle, except HOLD.
REQ-016 SHALL assert in_ready only in IDLE; only one operation in flight.
REQ-017 SHALL assert out_valid only in HOLD; out_valid is first seen high after the 4th rising edge following the accept edge (latency 4).
REQ-018 SHALL hold z and flags stable while out_valid && !out_ready.
REQ-019 SHALL return to IDLE on the edge where out_valid && out_ready; the next accept SHALL occur no earlier than the following edge.
REQ-020 UNPACK SHALL normalise subnormal inputs in one cycle: leading-zero count, left shift of the fraction, unbiased exponent set to 1-bias-lzc.
REQ-021 MUL SHALL form the exact (2*MAN_W+2)-bit significand product and an EXP_W+2-bit signed exponent sum; sign = a.sign XOR b.sign.
REQ-022 NORM SHALL shift to a leading 1. If the exponent is below emin, it SHALL right-shift into subnormal range, OR-ing the shifted-out bits into sticky.
REQ-023 ROUND SHALL apply rm using guard/round/sticky. RNE: ties to even. RTZ: truncate. RDN/RUP: increment when inexact and the sign is 1/0 respectively. Mantissa carry-out SHALL increment the exponent.
REQ-024 A NaN operand SHALL give canonical NaN z = {0, all-ones exponent, fraction MSB 1, rest 0}; invalid SHALL be set if either operand is a signalling NaN (fraction MSB 0).
REQ-025 Inf x 0 (either order) SHALL give canonical NaN with invalid=1; Inf x finite nonzero SHALL give signed Inf with no flags.
REQ-026 A zero operand (no Inf/NaN present) SHALL give signed zero with no flags.
REQ-027 On overflow, overflow=1 and inexact=1. Result: RNE gives Inf. RTZ gives max finite. RDN gives Inf if negative, else max finite. RUP gives Inf if positive, else max finite.
REQ-028 underflow SHALL be set only when the result is tiny (after rounding) and inexact; inexact SHALL be set when any discarded bit is nonzero.
REQ-029 Rounding up from the largest subnormal SHALL yield the smallest normal with exponent field 1.

Reset
REQ-030 With rst high at a clk edge, the block SHALL enter IDLE, and z, flags and out_valid SHALL be 0 while in_ready is 1, regardless of state, including mid-operation and in HOLD.
REQ-031 An operation in flight at reset SHALL be discarded with no out_valid pulse; rst SHALL take priority over a simultaneous in_valid.

Verification (EXP_W=8, MAN_W=23)
REQ-032 a=0x3FC00000, b=0x40000000, rm=0 -> z=0x40400000, flags=0, out_valid exactly 4 edges after accept.
REQ-033 a=0x7F7FFFFF, b=0x40000000: rm=0 -> z=0x7F800000, flags=0b0101; rm=1 -> z=0x7F7FFFFF, flags=0b0101.
REQ-034 a=0x7F800000, b=0x00000000 -> z=0x7FC00000, flags=0b1000; a=0x7F800001, b=0x3F800000 -> z=0x7FC00000, flags=0b1000.
REQ-035 a=0x00800000, b=0x3F000000 -> z=0x00400000, flags=0; a=0x00000001, b=0x3F000000, rm=0 -> z=0x00000000, flags=0b0011.
REQ-036 out_ready held low for 10 cycles -> z/flags/out_valid stable and in_ready=0 throughout; rst asserted in MUL -> no out_valid, in_ready=1 on the next cycle.

Source files
------------

// File: rtl/fp_mul_hs.sv
// Multi-cycle IEEE-754-style multiplier with a valid/ready handshake on both sides.
// One operation in flight; stages UNPACK, MUL, NORM, ROUND each take one cycle.
module fp_mul_hs #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   input  logic [1:0]           rm,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] z,
   output logic [3:0]           flags
);
   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int BIAS = (1 << (EXP_W - 1)) - 1;
   localparam int SW   = MAN_W + 1;
   localparam int PW   = 2 * MAN_W + 2;
   localparam int EW   = EXP_W + 2;
   localparam int MW2  = MAN_W + 2;
   localparam logic [EW-1:0] EMIN = EW'(1 - BIAS);
   localparam logic [EW-1:0] EOVF = EW'((1 << EXP_W) - 1);
   localparam logic [W-1:0]  QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, UNPACK, MUL, NORM, ROUND, HOLD} state_t;
   state_t state;

   logic [W-1:0]    ra, rb;
   logic [1:0]      rrm;
   logic [SW-1:0]   siga, sigb;
   logic [EW-1:0]   ea, eb, esum;
   logic            sp_hit;
   logic [W-1:0]    sp_z;
   logic [3:0]      sp_f;
   logic [PW-1:0]   prod;
   logic [EW-1:0]   n_be;
   logic [SW-1:0]   n_man;
   logic            n_g, n_r, n_s;

   function automatic logic [EW-1:0] lzc_f(input logic [SW-1:0] v);
      lzc_f = EW'(SW);
      for (int i = 0; i < SW; i++)
         if (v[i]) lzc_f = EW'(SW - 1 - i);
   endfunction

   // Subnormals are normalised here so MUL always sees a leading 1 at bit MAN_W.
   function automatic logic [SW-1:0] sig_f(input logic [W-2:0] v);
      if (v[W-2:MAN_W] == '0) sig_f = {1'b0, v[MAN_W-1:0]} << lzc_f({1'b0, v[MAN_W-1:0]});
      else                    sig_f = {1'b1, v[MAN_W-1:0]};
   endfunction

   function automatic logic [EW-1:0] exp_f(input logic [W-2:0] v);
      if (v[W-2:MAN_W] == '0) exp_f = EW'(1) - EW'(BIAS) - lzc_f({1'b0, v[MAN_W-1:0]});
      else                    exp_f = EW'(v[W-2:MAN_W]) - EW'(BIAS);
   endfunction

   // operand classification
   logic [EXP_W-1:0] xa, xb;
   logic [MAN_W-1:0] fa, fb;
   logic             sgn, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
   assign xa     = ra[W-2:MAN_W];
   assign xb     = rb[W-2:MAN_W];
   assign fa     = ra[MAN_W-1:0];
   assign fb     = rb[MAN_W-1:0];
   assign sgn    = ra[W-1] ^ rb[W-1];
   assign a_zero = (xa == '0) && (fa == '0);
   assign b_zero = (xb == '0) && (fb == '0);
   assign a_inf  = (&xa) && (fa == '0);
   assign b_inf  = (&xb) && (fb == '0);
   assign a_nan  = (&xa) && (|fa);
   assign b_nan  = (&xb) && (|fb);
   assign a_snan = a_nan && !fa[MAN_W-1];
   assign b_snan = b_nan && !fb[MAN_W-1];

   logic         sp_hit_c;
   logic [W-1:0] sp_z_c;
   logic [3:0]   sp_f_c;
   always_comb begin
      sp_hit_c = 1'b1;
      sp_z_c   = QNAN;
      sp_f_c   = 4'b0000;
      if (a_nan || b_nan)                             sp_f_c = {a_snan | b_snan, 3'b000};
      else if ((a_inf && b_zero) || (b_inf && a_zero)) sp_f_c = 4'b1000;
      else if (a_inf || b_inf)                         sp_z_c = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (a_zero || b_zero)                       sp_z_c = {sgn, {(W-1){1'b0}}};
      else                                             sp_hit_c = 1'b0;
   end

   // NORM: leading 1 to the MSB, then denormalise below emin with sticky collection
   logic [PW-1:0] nm, nsh;
   logic [EW-1:0] ne, nbe, dsh;
   logic          nst;
   always_comb begin
      if (prod[PW-1]) begin nm = prod;      ne = esum + EW'(1); end
      else            begin nm = prod << 1; ne = esum;          end
      dsh = '0;
      nsh = nm;
      nst = 1'b0;
      nbe = ne + EW'(BIAS);
      if ($signed(ne) < $signed(EMIN)) begin
         dsh = EMIN - ne;
         nst = |(nm & ~({PW{1'b1}} << dsh));
         nsh = nm >> dsh;
         nbe = EW'(1);
      end
   end

   // ROUND: a subnormal carrying into bit MAN_W naturally lands on exponent field 1
   logic             inx, inc, to_inf;
   logic [MW2-1:0]   mr;
   logic [EW-1:0]    fe;
   logic [MAN_W-1:0] fr;
   logic [W-1:0]     rz;
   logic [3:0]       rf;
   always_comb begin
      inx = n_g | n_r | n_s;
      case (rrm)
         2'd0:    inc = n_g & (n_r | n_s | n_man[0]);
         2'd1:    inc = 1'b0;
         2'd2:    inc = inx & sgn;
         default: inc = inx & ~sgn;
      endcase
      mr = {1'b0, n_man} + MW2'(inc);
      if (mr[MAN_W+1]) begin fe = n_be + EW'(1);         fr = mr[MAN_W:1];   end
      else             begin fe = mr[MAN_W] ? n_be : '0; fr = mr[MAN_W-1:0]; end
      to_inf = (rrm == 2'd0) || (rrm == 2'd2 && sgn) || (rrm == 2'd3 && !sgn);
      if (sp_hit) begin
         rz = sp_z;
         rf = sp_f;
      end else if ($signed(fe) >= $signed(EOVF)) begin
         rz = to_inf ? {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                     : {sgn, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
         rf = 4'b0101;
      end else begin
         rz = {sgn, fe[EXP_W-1:0], fr};
         rf = {2'b00, (fe == '0) & inx, inx};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         z         <= '0;
         flags     <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid && in_ready) begin
               ra       <= a;
               rb       <= b;
               rrm      <= rm;
               in_ready <= 1'b0;
               state    <= UNPACK;
            end
            UNPACK: begin
               siga   <= sig_f(ra[W-2:0]);
               sigb   <= sig_f(rb[W-2:0]);
               ea     <= exp_f(ra[W-2:0]);
               eb     <= exp_f(rb[W-2:0]);
               sp_hit <= sp_hit_c;
               sp_z   <= sp_z_c;
               sp_f   <= sp_f_c;
               state  <= MUL;
            end
            MUL: begin
               prod  <= PW'(siga) * PW'(sigb);
               esum  <= ea + eb;
               state <= NORM;
            end
            NORM: begin
               n_be  <= nbe;
               n_man <= nsh[PW-1 -: SW];
               n_g   <= nsh[PW-1-SW];
               n_r   <= nsh[PW-2-SW];
               n_s   <= (|nsh[PW-3-SW:0]) | nst;
               state <= ROUND;
            end
            ROUND: begin
               z         <= rz;
               flags     <= rf;
               out_valid <= 1'b1;
               state     <= HOLD;
            end
            HOLD: if (out_ready) begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_mul_hs.sv
// Bench for fp_mul_hs (binary32): directed corner cases, handshake/reset scenarios and
// random operands checked against a value-level rounding model.
module tb_fp_mul_hs;
   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] a, b, z;
   logic [1:0]  rm;
   logic [3:0]  flags;
   int          total = 0;
   int          bad = 0;

   fp_mul_hs #(.EXP_W(8), .MAN_W(23)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .rm(rm),
      .out_valid(out_valid), .out_ready(out_ready), .z(z), .flags(flags)
   );

   always #5 clk = ~clk;

   // exact product sig*2^e, rounded to the binary32 grid for that magnitude
   function automatic void ref_mul(input logic [31:0] xa, input logic [31:0] xb, input logic [1:0] mode,
                                   output logic [31:0] ez, output logic [3:0] ef);
      logic s, na, nb, sna, snb, ia, ib, za, zb, up, rnz, gt, eq;
      longint unsigned sga, sgb, p, m, rem, half;
      int ea, eb, e, msb, lead, q, sh, field;
      s   = xa[31] ^ xb[31];
      na  = xa[30:23] == 8'hFF && xa[22:0] != 0;
      nb  = xb[30:23] == 8'hFF && xb[22:0] != 0;
      sna = na && !xa[22];
      snb = nb && !xb[22];
      ia  = xa[30:23] == 8'hFF && xa[22:0] == 0;
      ib  = xb[30:23] == 8'hFF && xb[22:0] == 0;
      za  = xa[30:0] == 0;
      zb  = xb[30:0] == 0;
      ez  = '0;
      ef  = '0;
      if (na || nb) begin
         ez = 32'h7FC00000; ef = {sna || snb, 3'b000};
      end else if ((ia && zb) || (ib && za)) begin
         ez = 32'h7FC00000; ef = 4'b1000;
      end else if (ia || ib) begin
         ez = {s, 8'hFF, 23'h0};
      end else if (za || zb) begin
         ez = {s, 31'h0};
      end else begin
         sga = (xa[30:23] == 0) ? {41'h0, xa[22:0]} : {40'h0, 1'b1, xa[22:0]};
         sgb = (xb[30:23] == 0) ? {41'h0, xb[22:0]} : {40'h0, 1'b1, xb[22:0]};
         ea  = (xa[30:23] == 0) ? -149 : int'(xa[30:23]) - 150;
         eb  = (xb[30:23] == 0) ? -149 : int'(xb[30:23]) - 150;
         p   = sga * sgb;
         e   = ea + eb;
         msb = 0;
         for (int i = 0; i < 64; i++) if (p[i]) msb = i;
         lead = msb + e;
         q    = (lead < -126) ? -149 : lead - 23;
         sh   = q - e;
         if (sh > 60) begin
            m = 0; rnz = 1'b1; gt = 1'b0; eq = 1'b0;
         end else begin
            m    = p >> sh;
            rem  = p & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            rnz  = rem != 0;
            gt   = rem > half;
            eq   = rem == half;
         end
         case (mode)
            2'd0:    up = gt || (eq && m[0]);
            2'd1:    up = 1'b0;
            2'd2:    up = rnz && s;
            default: up = rnz && !s;
         endcase
         m = m + 64'(up);
         if (m == (64'd1 << 24)) begin m = m >> 1; q++; end
         field = (m < (64'd1 << 23)) ? 0 : q + 150;
         if (field >= 255) begin
            ef = 4'b0101;
            if (mode == 2'd0 || (mode == 2'd2 && s) || (mode == 2'd3 && !s)) ez = {s, 8'hFF, 23'h0};
            else                                                              ez = {s, 8'hFE, 23'h7FFFFF};
         end else begin
            ez = {s, field[7:0], m[22:0]};
            ef = {2'b00, field == 0 && rnz, rnz};
         end
      end
   endfunction

   function automatic logic [22:0] gen_frac();
      case ($urandom_range(0, 5))
         0:       return 23'h0;
         1:       return 23'h7FFFFF;
         2:       return 23'h1 << $urandom_range(0, 22);
         default: return 23'($urandom);
      endcase
   endfunction

   // Drives one operation; operands are scrambled and in_valid left high while busy.
   task automatic do_op(input logic [31:0] xa, input logic [31:0] xb, input logic [1:0] trm,
                        input int stall, output logic [31:0] oz, output logic [3:0] of, output int lat);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL ready_wait in_ready=%b required 1", in_ready); end
      a = xa; b = xb; rm = trm; in_valid = 1'b1;
      @(posedge clk); #1;
      a = $urandom; b = $urandom; rm = 2'($urandom);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
      in_valid = 1'b0;
      oz = z; of = flags;
      total++;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL op_timeout out_valid=%b required 1", out_valid); end
      repeat (stall) begin @(posedge clk); #1; end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b1; a = 32'h3F800000; b = 32'h3F800000; rm = 2'd0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
      total++; if (z !== 32'h0)        begin bad++; $display("FAIL rst_z got=%h want=0", z); end
      total++; if (flags !== 4'h0)     begin bad++; $display("FAIL rst_flags got=%b want=0", flags); end
      rst = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL rst_priority in_ready=%b want=1", in_ready); end
   endtask

   task automatic test_directed;
      logic [31:0] va[14], vb[14], vz[14], oz;
      logic [1:0]  vr[14];
      logic [3:0]  vf[14], of;
      int lat;
      va = '{32'h3FC00000, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 32'h7F800001, 32'h00800000, 32'h00000001,
             32'hFF7FFFFF, 32'hFF7FFFFF, 32'h00FFFFFF, 32'h00FFFFFF, 32'h7FC00001, 32'h00000000, 32'h80000000};
      vb = '{32'h40000000, 32'h40000000, 32'h40000000, 32'h00000000, 32'h3F800000, 32'h3F000000, 32'h3F000000,
             32'h40000000, 32'h40000000, 32'h3F000000, 32'h3F000000, 32'h00000000, 32'hFF800000, 32'h3F800000};
      vr = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
      vz = '{32'h40400000, 32'h7F800000, 32'h7F7FFFFF, 32'h7FC00000, 32'h7FC00000, 32'h00400000, 32'h00000000,
             32'hFF800000, 32'hFF7FFFFF, 32'h00800000, 32'h007FFFFF, 32'h7FC00000, 32'h7FC00000, 32'h80000000};
      vf = '{4'h0, 4'h5, 4'h5, 4'h8, 4'h8, 4'h0, 4'h3, 4'h5, 4'h5, 4'h1, 4'h3, 4'h0, 4'h8, 4'h0};
      for (int i = 0; i < 14; i++) begin
         do_op(va[i], vb[i], vr[i], i % 3, oz, of, lat);
         total++; if (oz !== vz[i]) begin bad++; $display("FAIL dir_z[%0d] got=%h want=%h", i, oz, vz[i]); end
         total++; if (of !== vf[i]) begin bad++; $display("FAIL dir_flags[%0d] got=%b want=%b", i, of, vf[i]); end
         total++; if (lat !== 4)    begin bad++; $display("FAIL dir_latency[%0d] got=%0d want=4", i, lat); end
      end
   endtask

   task automatic test_stall;
      int n;
      a = 32'h3FC00000; b = 32'h40000000; rm = 2'd0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      for (int c = 0; c < 10; c++) begin
         total++; if (out_valid !== 1'b1)   begin bad++; $display("FAIL stall_valid c=%0d got=%b want=1", c, out_valid); end
         total++; if (z !== 32'h40400000)   begin bad++; $display("FAIL stall_z c=%0d got=%h want=40400000", c, z); end
         total++; if (flags !== 4'h0)       begin bad++; $display("FAIL stall_flags c=%0d got=%b want=0", c, flags); end
         total++; if (in_ready !== 1'b0)    begin bad++; $display("FAIL stall_ready c=%0d got=%b want=0", c, in_ready); end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL release_valid got=%b want=0", out_valid); end
      total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL release_ready got=%b want=1", in_ready); end
   endtask

   task automatic test_reset_mid;
      logic seen;
      int n, lat;
      logic [31:0] oz;
      logic [3:0]  of;
      a = 32'h3FC00000; b = 32'h40000000; rm = 2'd0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL midrst_ready got=%b want=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", out_valid); end
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_pulse saw out_valid=1 want none"); end
      a = 32'h40000000; b = 32'h40000000; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL holdrst_valid got=%b want=0", out_valid); end
      total++; if (z !== 32'h0)        begin bad++; $display("FAIL holdrst_z got=%h want=0", z); end
      total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL holdrst_ready got=%b want=1", in_ready); end
      do_op(32'h40400000, 32'h40000000, 2'd0, 0, oz, of, lat);
      total++; if (oz !== 32'h40C00000) begin bad++; $display("FAIL recover_z got=%h want=40c00000", oz); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] qz[$];
      logic [3:0]  qf[$];
      int          qc[$];
      logic [31:0] ez, wz;
      logic [3:0]  ef, wf;
      int cyc, nout, last_acc, wc;
      logic acc;
      cyc = 0; nout = 0; last_acc = -1;
      out_ready = 1'b1; in_valid = 1'b1;
      a = $urandom; b = $urandom; rm = 2'($urandom);
      while (nout < 20 && cyc < 400) begin
         acc = in_ready;
         if (acc) begin ref_mul(a, b, rm, ez, ef); qz.push_back(ez); qf.push_back(ef); end
         @(posedge clk); #1;
         cyc++;
         if (acc) begin
            qc.push_back(cyc);
            if (last_acc >= 0) begin
               total++; if (cyc - last_acc !== 6) begin bad++; $display("FAIL b2b_gap got=%0d want=6", cyc - last_acc); end
            end
            last_acc = cyc;
            a = $urandom; b = $urandom; rm = 2'($urandom);
         end
         if (out_valid) begin
            total++;
            if (qz.size() == 0) begin
               bad++; $display("FAIL b2b_spurious out_valid=1 with nothing in flight");
            end else begin
               wz = qz.pop_front(); wf = qf.pop_front(); wc = qc.pop_front();
               if (z !== wz || flags !== wf || cyc - wc !== 4) begin
                  bad++;
                  $display("FAIL b2b_result z=%h flags=%b lat=%0d want z=%h flags=%b lat=4", z, flags, cyc - wc, wz, wf);
               end
            end
            nout++;
         end
      end
      in_valid = 1'b0;
      total++; if (nout !== 20) begin bad++; $display("FAIL b2b_count got=%0d want=20", nout); end
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_random;
      logic [31:0] opa, opb, oz, ez;
      logic [3:0]  of, ef;
      logic [7:0]  ya, yb;
      logic [1:0]  mode;
      int sum, lat;
      for (int k = 0; k < 300; k++) begin
         case ($urandom_range(0, 4))
            0: begin ya = 8'($urandom); yb = 8'($urandom); end
            1: begin sum = $urandom_range(95, 135); ya = 8'($urandom_range(0, sum)); yb = 8'(sum - int'(ya)); end
            2: begin sum = $urandom_range(376, 390); ya = 8'($urandom_range(sum - 254, 254)); yb = 8'(sum - int'(ya)); end
            3: begin ya = 8'h00; yb = 8'($urandom_range(100, 254)); end
            default: begin ya = 8'($urandom_range(1, 254)); yb = 8'($urandom_range(1, 254)); end
         endcase
         opa  = {1'($urandom), ya, gen_frac()};
         opb  = {1'($urandom), yb, gen_frac()};
         mode = 2'($urandom);
         ref_mul(opa, opb, mode, ez, ef);
         do_op(opa, opb, mode, $urandom_range(0, 2), oz, of, lat);
         total++; if (oz !== ez) begin bad++; $display("FAIL rnd_z a=%h b=%h rm=%0d got=%h want=%h", opa, opb, mode, oz, ez); end
         total++; if (of !== ef) begin bad++; $display("FAIL rnd_flags a=%h b=%h rm=%0d got=%b want=%b", opa, opb, mode, of, ef); end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
